// File: rtl/rx_field_sequencer.sv
// Field sequencer for the receive path: tracks which packet field is being
// shifted in, gates the per-field shift enables and flags complete/bad fields.
module rx_field_sequencer (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       shift_strobe,
   input  logic       eop,
   input  logic       sync_rcving,
   input  logic       pid_rcving,
   input  logic       crc5_rcving,
   input  logic       crc16_rcving,
   input  logic       data_rcving,
   output logic       sync_shift_enable,
   output logic       pid_shift_enable,
   output logic       crc5_shift_enable,
   output logic       crc16_shift_enable,
   output logic       data_shift_enable,
   output logic       sync_bits_received,
   output logic       pid_bits_received,
   output logic       crc5_bits_received,
   output logic       crc16_bits_received,
   output logic       data_bits_received,
   output logic [6:0] field_bit_count,
   output logic       field_error
);

   localparam int unsigned CNT_W = 7;
   localparam int unsigned SEL_W = 5;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(64);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   // Fields are identified by their one-hot select pattern; all-zero means none.
   function automatic logic [CNT_W-1:0] field_len(input logic [SEL_W-1:0] f);
      case (f)
         5'b00001: field_len = CNT_W'(8);
         5'b00010: field_len = CNT_W'(8);
         5'b00100: field_len = CNT_W'(5);
         5'b01000: field_len = CNT_W'(16);
         5'b10000: field_len = CNT_W'(64);
         default:  field_len = CNT_W'(0);
      endcase
   endfunction

   state_t             r_state;
   state_t             w_nxt_state;
   logic [SEL_W-1:0]   r_act;
   logic [SEL_W-1:0]   w_nxt_act;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_nxt_cnt;
   logic [CNT_W-1:0]   w_len;
   logic [SEL_W-1:0]   r_rx;
   logic               r_field_error;
   logic [SEL_W-1:0]   w_sel;
   logic               w_sel_none;
   logic               w_sel_single;
   logic               w_sel_multi;
   logic [SEL_W-1:0]   w_en;

   assign w_sel        = {data_rcving, crc16_rcving, crc5_rcving, pid_rcving, sync_rcving};
   assign w_sel_none   = (w_sel == '0);
   assign w_sel_single = $onehot(w_sel);
   assign w_sel_multi  = !w_sel_none && !w_sel_single;
   assign w_len        = field_len(r_act);

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= ST_IDLE;
      else        r_state <= w_nxt_state;
   end

   // Next state, active field and count
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_act   = r_act;
      w_nxt_cnt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_sel_single) begin
               w_nxt_state = ST_SHIFT;
               w_nxt_act   = w_sel;
               w_nxt_cnt   = '0;
            end else if (w_sel_multi) begin
               w_nxt_state = ST_ERR;
            end
         end
         ST_SHIFT: begin
            // eop outranks everything here: a field cut short is always an error
            if (eop) begin
               w_nxt_state = ST_ERR;
            end else if (w_sel_none) begin
               w_nxt_state = ST_IDLE;
               w_nxt_act   = '0;
            end else if (w_sel != r_act) begin
               w_nxt_state = ST_ERR;
            end else if (shift_strobe) begin
               if (r_cnt == w_len - CNT_W'(1)) begin
                  w_nxt_state = ST_DONE;
                  w_nxt_cnt   = w_len;
               end else if (r_cnt < CNT_MAX) begin
                  w_nxt_cnt   = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (w_sel_none) begin
               w_nxt_state = ST_IDLE;
               w_nxt_act   = '0;
            end else if (w_sel_multi) begin
               w_nxt_state = ST_ERR;
            end else if (w_sel != r_act) begin
               w_nxt_state = ST_SHIFT;
               w_nxt_act   = w_sel;
               w_nxt_cnt   = '0;
            end
         end
         ST_ERR: begin
            if (w_sel_none) begin
               w_nxt_state = ST_IDLE;
               w_nxt_act   = '0;
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
            w_nxt_act   = '0;
            w_nxt_cnt   = '0;
         end
      endcase
   end

   // Shift enables are live only for the field still selected, and never in reset
   always_comb begin
      w_en = '0;
      if (n_rst && shift_strobe && !eop && (r_state == ST_SHIFT) && (w_sel == r_act))
         w_en = r_act;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_act         <= '0;
         r_cnt         <= '0;
         r_rx          <= '0;
         r_field_error <= 1'b0;
      end else begin
         r_act         <= w_nxt_act;
         r_cnt         <= w_nxt_cnt;
         r_rx          <= (w_nxt_state == ST_DONE) ? w_nxt_act : '0;
         r_field_error <= (w_nxt_state == ST_ERR) && (r_state != ST_ERR);
      end
   end

   assign sync_shift_enable   = w_en[0];
   assign pid_shift_enable    = w_en[1];
   assign crc5_shift_enable   = w_en[2];
   assign crc16_shift_enable  = w_en[3];
   assign data_shift_enable   = w_en[4];
   assign sync_bits_received  = r_rx[0];
   assign pid_bits_received   = r_rx[1];
   assign crc5_bits_received  = r_rx[2];
   assign crc16_bits_received = r_rx[3];
   assign data_bits_received  = r_rx[4];
   assign field_bit_count     = (r_cnt > CNT_MAX) ? CNT_MAX : r_cnt;
   assign field_error         = r_field_error;

endmodule

// File: tb/tb_rx_field_sequencer.sv
// Bench for rx_field_sequencer: directed field scenarios followed by random
// select/strobe/eop traffic, all checked against a field-level reference model.
module tb_rx_field_sequencer;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       shift_strobe = 1'b0;
   logic       eop = 1'b0;
   logic [4:0] sel = 5'b0;

   logic sync_shift_enable, pid_shift_enable, crc5_shift_enable, crc16_shift_enable, data_shift_enable;
   logic sync_bits_received, pid_bits_received, crc5_bits_received, crc16_bits_received, data_bits_received;
   logic [6:0] field_bit_count;
   logic       field_error;

   rx_field_sequencer dut (
      .clk                 (clk),
      .n_rst               (n_rst),
      .shift_strobe        (shift_strobe),
      .eop                 (eop),
      .sync_rcving         (sel[0]),
      .pid_rcving          (sel[1]),
      .crc5_rcving         (sel[2]),
      .crc16_rcving        (sel[3]),
      .data_rcving         (sel[4]),
      .sync_shift_enable   (sync_shift_enable),
      .pid_shift_enable    (pid_shift_enable),
      .crc5_shift_enable   (crc5_shift_enable),
      .crc16_shift_enable  (crc16_shift_enable),
      .data_shift_enable   (data_shift_enable),
      .sync_bits_received  (sync_bits_received),
      .pid_bits_received   (pid_bits_received),
      .crc5_bits_received  (crc5_bits_received),
      .crc16_bits_received (crc16_bits_received),
      .data_bits_received  (data_bits_received),
      .field_bit_count     (field_bit_count),
      .field_error         (field_error)
   );

   always #5 clk = ~clk;

   wire [4:0] w_en_v = {data_shift_enable, crc16_shift_enable, crc5_shift_enable,
                        pid_shift_enable, sync_shift_enable};
   wire [4:0] w_rx_v = {data_bits_received, crc16_bits_received, crc5_bits_received,
                        pid_bits_received, sync_bits_received};

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 collecting a field, 2 field complete, 3 error
   int LEN [5] = '{8, 8, 5, 16, 64};
   int m_mode = 0;
   int m_fld  = -1;
   int m_cnt  = 0;
   bit m_ferr = 1'b0;

   int en_tally [5];
   int rx_tally [5];
   int ferr_tally;

   function automatic int sel_idx(input logic [4:0] s);
      for (int i = 0; i < 5; i++) if (s[i]) return i;
      return -1;
   endfunction

   function automatic logic [4:0] exp_en();
      logic [4:0] v = 5'b0;
      if (n_rst && m_mode == 1 && shift_strobe && !eop && $countones(sel) == 1 && sel_idx(sel) == m_fld)
         v[m_fld] = 1'b1;
      return v;
   endfunction

   function automatic logic [4:0] exp_rx();
      logic [4:0] v = 5'b0;
      if (m_mode == 2) v[m_fld] = 1'b1;
      return v;
   endfunction

   task automatic model_step();
      int  n   = $countones(sel);
      int  idx = sel_idx(sel);
      int  old = m_mode;
      case (m_mode)
         0: if (n == 1) begin m_mode = 1; m_fld = idx; m_cnt = 0; end
            else if (n > 1) m_mode = 3;
         1: if (eop) m_mode = 3;
            else if (n == 0) m_mode = 0;
            else if (n > 1 || idx != m_fld) m_mode = 3;
            else if (shift_strobe) begin
               m_cnt++;
               if (m_cnt == LEN[m_fld]) m_mode = 2;
            end
         2: if (n == 0) m_mode = 0;
            else if (n > 1) m_mode = 3;
            else if (idx != m_fld) begin m_mode = 1; m_fld = idx; m_cnt = 0; end
         default: if (n == 0) m_mode = 0;
      endcase
      m_ferr = (m_mode == 3) && (old != 3);
   endtask

   task automatic clr_tally();
      for (int i = 0; i < 5; i++) begin en_tally[i] = 0; rx_tally[i] = 0; end
      ferr_tally = 0;
   endtask

   // One clock: check registered outputs, drive inputs, check enables, advance model
   task automatic cycle(input logic stb, input logic e, input logic [4:0] s);
      @(negedge clk);
      check("bits_received", 32'(w_rx_v), 32'(exp_rx()));
      check("field_bit_count", 32'(field_bit_count), 32'(m_cnt));
      check("field_error", 32'(field_error), 32'(m_ferr));
      for (int i = 0; i < 5; i++) if (w_rx_v[i]) rx_tally[i]++;
      if (field_error) ferr_tally++;
      shift_strobe = stb;
      eop          = e;
      sel          = s;
      #1;
      check("shift_enable", 32'(w_en_v), 32'(exp_en()));
      for (int i = 0; i < 5; i++) if (w_en_v[i]) en_tally[i]++;
      @(posedge clk);
      model_step();
   endtask

   task automatic apply_reset(input logic stb);
      @(negedge clk);
      #2;
      n_rst        = 1'b0;
      shift_strobe = stb;
      #1;
      check("rst_enable", 32'(w_en_v), 32'd0);
      check("rst_bits_received", 32'(w_rx_v), 32'd0);
      check("rst_count", 32'(field_bit_count), 32'd0);
      check("rst_field_error", 32'(field_error), 32'd0);
      m_mode = 0; m_fld = -1; m_cnt = 0; m_ferr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1; shift_strobe = 1'b0; eop = 1'b0; sel = 5'b0;
   endtask

   task automatic strobes(input int num, input int gap, input logic [4:0] s);
      for (int k = 0; k < num; k++) begin
         cycle(1'b1, 1'b0, s);
         for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, s);
      end
   endtask

   initial begin
      clr_tally();
      apply_reset(1'b1);

      // sync with spaced strobes
      clr_tally();
      cycle(1'b0, 1'b0, 5'b00001);
      strobes(8, 3, 5'b00001);
      #2;
      check("sync_enable_pulses", 32'(en_tally[0]), 32'd8);
      check("sync_count", 32'(field_bit_count), 32'd8);
      check("sync_received", 32'(sync_bits_received), 32'd1);

      // straight into pid
      cycle(1'b0, 1'b0, 5'b00010);
      #2;
      check("pid_count_restart", 32'(field_bit_count), 32'd0);
      strobes(8, 1, 5'b00010);
      #2;
      check("pid_received", 32'(pid_bits_received), 32'd1);
      check("pid_no_error", 32'(ferr_tally), 32'd0);
      cycle(1'b0, 1'b0, 5'b00000);

      // data truncated by eop
      clr_tally();
      cycle(1'b0, 1'b0, 5'b10000);
      strobes(40, 0, 5'b10000);
      cycle(1'b1, 1'b1, 5'b10000);
      for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 5'b10000);
      #2;
      check("trunc_count_held", 32'(field_bit_count), 32'd40);
      check("trunc_error_pulses", 32'(ferr_tally), 32'd1);
      check("trunc_no_data_rx", 32'(rx_tally[4]), 32'd0);
      cycle(1'b0, 1'b0, 5'b00000);

      // two selects at once
      clr_tally();
      cycle(1'b0, 1'b0, 5'b00011);
      strobes(4, 0, 5'b00011);
      cycle(1'b0, 1'b0, 5'b00000);
      check("multi_error_pulses", 32'(ferr_tally), 32'd1);
      check("multi_no_enables", 32'(en_tally[0] + en_tally[1]), 32'd0);

      // crc5 with extra strobes after completion
      clr_tally();
      cycle(1'b0, 1'b0, 5'b00100);
      strobes(8, 0, 5'b00100);
      #2;
      check("crc5_enable_pulses", 32'(en_tally[2]), 32'd5);
      check("crc5_count", 32'(field_bit_count), 32'd5);
      cycle(1'b0, 1'b0, 5'b00000);

      // reset in the middle of data, then a full data field
      cycle(1'b0, 1'b0, 5'b10000);
      strobes(30, 0, 5'b10000);
      apply_reset(1'b1);
      clr_tally();
      cycle(1'b0, 1'b0, 5'b10000);
      #2;
      check("post_reset_count", 32'(field_bit_count), 32'd0);
      strobes(64, 0, 5'b10000);
      #2;
      check("data_count", 32'(field_bit_count), 32'd64);
      check("data_received", 32'(data_bits_received), 32'd1);
      check("data_enable_pulses", 32'(en_tally[4]), 32'd64);
      cycle(1'b0, 1'b0, 5'b00000);

      // random traffic
      for (int t = 0; t < 4000; t++) begin
         logic [4:0] s = sel;
         if ($urandom_range(0, 99) < 2) begin
            int r = $urandom_range(0, 9);
            if (r < 3) s = 5'b0;
            else if (r < 9) begin s = 5'b0; s[$urandom_range(0, 4)] = 1'b1; end
            else begin
               s = 5'($urandom_range(0, 31));
               while ($countones(s) < 2) s = 5'($urandom_range(0, 31));
            end
         end
         if ($urandom_range(0, 999) < 3) apply_reset(1'($urandom_range(0, 1)));
         else cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0), s);
      end
      cycle(1'b0, 1'b0, 5'b00000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
